// File: rtl/pe_ctrl_pkg.sv
// Shared opcode encodings, DSP48 control field widths and the per-lane decode
// used by the PE-array control sequencer.
package pe_ctrl_pkg;

    localparam logic [2:0] OP_ADD    = 3'b001;
    localparam logic [2:0] OP_SUB    = 3'b010;
    localparam logic [2:0] OP_MUL    = 3'b100;
    localparam logic [2:0] OP_MULADD = 3'b101;
    localparam logic [2:0] OP_MULSUB = 3'b110;
    localparam logic [2:0] OP_MAX    = 3'b111;

    localparam int ALUMODE_W = 4;
    localparam int INMODE_W  = 5;
    localparam int OPMODE_W  = 7;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } pe_state_e;

    typedef struct packed {
        logic [ALUMODE_W-1:0] alumode;
        logic [INMODE_W-1:0]  inmode;
        logic [OPMODE_W-1:0]  opmode;
        logic                 ce2;
        logic                 usemult;
    } lane_ctrl_t;

    // Odd lanes accumulate the product (MULADD/MULSUB), even lanes only multiply.
    function automatic lane_ctrl_t pe_decode(input logic [2:0] op, input logic odd);
        lane_ctrl_t c;
        c = '0;
        case (op)
            OP_ADD: begin
                c.opmode = 7'b0110011;
                c.ce2    = 1'b1;
            end
            OP_SUB: begin
                c.alumode = 4'b0011;
                c.opmode  = 7'b0110011;
                c.ce2     = 1'b1;
            end
            OP_MUL, OP_MAX: begin
                c.inmode  = 5'b10001;
                c.opmode  = 7'b0000101;
                c.usemult = 1'b1;
            end
            OP_MULADD, OP_MULSUB: begin
                c.inmode  = 5'b10001;
                c.opmode  = odd ? 7'b0110101 : 7'b0000101;
                c.usemult = 1'b1;
                if (odd && (op == OP_MULSUB)) begin
                    c.alumode = 4'b0011;
                end else begin
                    c.alumode = 4'b0000;
                end
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pe_ctrl_valid_pipe.sv
// DELAY-deep valid shift register tracking issued ops through the PE pipeline;
// synchronous clear drops every in-flight bit.
module pe_ctrl_valid_pipe #(
    parameter int DELAY = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic din,
    output logic dout,
    output logic any
);

    logic [DELAY-1:0] sr_r;

    // Shift register with reset and clear
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sr_r <= '0;
        end else begin
            sr_r <= {sr_r[DELAY-2:0], din};
        end
    end

    assign dout = sr_r[DELAY-1];
    assign any  = |sr_r;

endmodule

// File: rtl/pe_ctrl_seq.sv
// PE-array instruction sequencer: repeats each accepted opcode for rep_cnt+1 cycles,
// drives per-lane DSP48 controls and muxes data onto dout. Optional abort: PE_CTRL_ABORT_EN.
module pe_ctrl_seq
    import pe_ctrl_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 32,
    parameter int DELAY     = 6,
    parameter int REP_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inst_v,
    output logic                   inst_rdy,
    input  logic [2:0]             opcode,
    input  logic [REP_W-1:0]       rep_cnt,
    input  logic                   din_pe_v,
    input  logic [DATA_W-1:0]      din_pe,
    input  logic                   din_shift_v,
    input  logic [DATA_W-1:0]      din_shift,
    input  logic                   din_tx_v,
    input  logic [DATA_W-1:0]      din_tx,
    output logic                   dout_v,
    output logic [DATA_W-1:0]      dout,
    output logic                   busy,
    output logic [4*NUM_LANES-1:0] alumode,
    output logic [5*NUM_LANES-1:0] inmode,
    output logic [7*NUM_LANES-1:0] opmode,
    output logic [NUM_LANES-1:0]   cea2,
    output logic [NUM_LANES-1:0]   ceb2,
    output logic [NUM_LANES-1:0]   usemult
`ifdef PE_CTRL_ABORT_EN
    ,
    input  logic                   abort
`endif
);

    pe_state_e              state_r, state_next_s;
    logic [REP_W-1:0]       cnt_r, cnt_next_s;
    logic [4*NUM_LANES-1:0] alumode_r, alumode_next_s, alumode_dec_s;
    logic [5*NUM_LANES-1:0] inmode_r, inmode_next_s, inmode_dec_s;
    logic [7*NUM_LANES-1:0] opmode_r, opmode_next_s, opmode_dec_s;
    logic [NUM_LANES-1:0]   ce2_r, ce2_next_s, ce2_dec_s;
    logic [NUM_LANES-1:0]   usemult_r, usemult_next_s, usemult_dec_s;
    logic [DATA_W-1:0]      dout_r;
    logic                   abort_s, inst_rdy_s, accept_s, inflight_s, dout_v_s;

`ifdef PE_CTRL_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign inst_rdy_s = !rst && !abort_s &&
                        ((state_r == ST_IDLE) || ((state_r == ST_ISSUE) && (cnt_r == '0)));
    assign accept_s   = inst_v && inst_rdy_s;

    // Decode the incoming opcode for every lane
    always_comb begin : decode_lanes
        lane_ctrl_t lc;
        alumode_dec_s = '0;
        inmode_dec_s  = '0;
        opmode_dec_s  = '0;
        ce2_dec_s     = '0;
        usemult_dec_s = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lc = pe_decode(opcode, (i % 2) == 1);
            alumode_dec_s[4*i +: 4] = lc.alumode;
            inmode_dec_s[5*i +: 5]  = lc.inmode;
            opmode_dec_s[7*i +: 7]  = lc.opmode;
            ce2_dec_s[i]            = lc.ce2;
            usemult_dec_s[i]        = lc.usemult;
        end
    end

    // Next state, repeat counter and next control word; zero controls mean LOAD
    always_comb begin
        state_next_s   = state_r;
        cnt_next_s     = cnt_r;
        alumode_next_s = alumode_r;
        inmode_next_s  = inmode_r;
        opmode_next_s  = opmode_r;
        ce2_next_s     = ce2_r;
        usemult_next_s = usemult_r;
        if (abort_s) begin
            state_next_s   = ST_IDLE;
            cnt_next_s     = '0;
            alumode_next_s = '0;
            inmode_next_s  = '0;
            opmode_next_s  = '0;
            ce2_next_s     = '0;
            usemult_next_s = '0;
        end else if (accept_s) begin
            state_next_s   = ST_ISSUE;
            cnt_next_s     = rep_cnt;
            alumode_next_s = alumode_dec_s;
            inmode_next_s  = inmode_dec_s;
            opmode_next_s  = opmode_dec_s;
            ce2_next_s     = ce2_dec_s;
            usemult_next_s = usemult_dec_s;
        end else begin
            case (state_r)
                ST_ISSUE: begin
                    if (cnt_r == '0) begin
                        state_next_s   = ST_IDLE;
                        alumode_next_s = '0;
                        inmode_next_s  = '0;
                        opmode_next_s  = '0;
                        ce2_next_s     = '0;
                        usemult_next_s = '0;
                    end else begin
                        cnt_next_s = cnt_r - REP_W'(1);
                    end
                end
                ST_IDLE: begin
                    state_next_s = ST_IDLE;
                end
                default: begin
                    state_next_s   = ST_IDLE;
                    cnt_next_s     = '0;
                    alumode_next_s = '0;
                    inmode_next_s  = '0;
                    opmode_next_s  = '0;
                    ce2_next_s     = '0;
                    usemult_next_s = '0;
                end
            endcase
        end
    end

    // State, counter and control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            alumode_r <= '0;
            inmode_r  <= '0;
            opmode_r  <= '0;
            ce2_r     <= '0;
            usemult_r <= '0;
        end else begin
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            alumode_r <= alumode_next_s;
            inmode_r  <= inmode_next_s;
            opmode_r  <= opmode_next_s;
            ce2_r     <= ce2_next_s;
            usemult_r <= usemult_next_s;
        end
    end

    // Priority data mux, holds when no source is valid
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r <= '0;
        end else if (din_pe_v) begin
            dout_r <= din_pe;
        end else if (din_shift_v) begin
            dout_r <= din_shift;
        end else if (din_tx_v) begin
            dout_r <= din_tx;
        end else begin
            dout_r <= dout_r;
        end
    end

    pe_ctrl_valid_pipe #(.DELAY(DELAY)) u_valid_pipe (
        .clk  (clk),
        .rst  (rst),
        .clr  (abort_s),
        .din  (state_r == ST_ISSUE),
        .dout (dout_v_s),
        .any  (inflight_s)
    );

    assign inst_rdy = inst_rdy_s;
    assign dout_v   = dout_v_s;
    assign dout     = dout_r;
    assign busy     = (state_r == ST_ISSUE) || inflight_s;
    assign alumode  = alumode_r;
    assign inmode   = inmode_r;
    assign opmode   = opmode_r;
    assign cea2     = ce2_r;
    assign ceb2     = ce2_r;
    assign usemult  = usemult_r;

endmodule
